// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART receiver: FSM states, register map and baud helper.
package servant_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_t;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_OVR   = 2;
    localparam int unsigned STAT_FERR  = 3;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Small receive FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module servant_uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             push_ok
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/servant_uart_rx.sv
// UART 8N1 receiver with a Wishbone slave interface, receive FIFO and pending-data interrupt.
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 16000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_rx,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);
    localparam int unsigned   DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned   CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    logic          rx_meta_q, rxs_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic          ferr_q, ovr_q;
    logic [7:0]    head;
    logic          empty, full, push_ok;
    logic          stop_sample, push, pop, bus_req, rd_req, wr_status;
    logic [31:0]   status_word;
    logic          unused_dat;

    assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            unique case (state_q)
                StIdle: if (!rxs_q) begin
                    cnt_q   <= CNT_HALF;
                    state_q <= StStart;
                end
                StStart: if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        cnt_q   <= CNT_BIT;
                        idx_q   <= '0;
                        state_q <= StData;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StData: if (cnt_q == '0) begin
                    sh_q  <= {rxs_q, sh_q[7:1]};
                    cnt_q <= CNT_BIT;
                    if (idx_q == 3'd7) state_q <= StStop;
                    else               idx_q   <= idx_q + 1'b1;
                end
                StStop: if (cnt_q == '0) begin
                    state_q <= rxs_q ? StIdle : StBreak;
                end
                StBreak: if (rxs_q) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // The stop-bit sample pushes directly so a same-cycle DATA read can make room.
    assign stop_sample = (state_q == StStop) && (cnt_q == '0);
    assign push        = stop_sample & rxs_q;
    assign bus_req     = i_wb_cyc & ~o_wb_ack;
    assign rd_req      = bus_req & ~i_wb_we;
    assign pop         = rd_req & (i_wb_adr == ADR_DATA);
    assign wr_status   = bus_req & i_wb_we & (i_wb_adr == ADR_STATUS);

    servant_uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .push    (push),
        .pop     (pop),
        .din     (sh_q),
        .dout    (head),
        .empty   (empty),
        .full    (full),
        .push_ok (push_ok)
    );

    always_comb begin
        status_word             = '0;
        status_word[STAT_VALID] = ~empty;
        status_word[STAT_FULL]  = full;
        status_word[STAT_OVR]   = ovr_q;
        status_word[STAT_FERR]  = ferr_q;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            // Setting has priority over a same-cycle W1C.
            ovr_q    <= (ovr_q & ~(wr_status & i_wb_dat[STAT_OVR])) | (push & ~push_ok);
            ferr_q   <= (ferr_q & ~(wr_status & i_wb_dat[STAT_FERR])) | (stop_sample & ~rxs_q);
            o_wb_ack <= bus_req;
            if (rd_req) begin
                if (i_wb_adr == ADR_STATUS) o_wb_rdt <= status_word;
                else                        o_wb_rdt <= empty ? 32'd0 : {24'd0, head};
            end
        end
    end

    assign o_irq = ~empty;

endmodule
